acq_transpose_fifo: RTL and testbench
=====================================

Name: acq_transpose_fifo

Overview:
Parametrised successor of the acquisition buffer. Stores packed multi-sample ADC words in an inferred simple-dual-port RAM, tracks exact occupancy, and on each read emits the stored word transposed into per-nibble output lanes for the UART/PSRAM packer. Sits between the sample capture stage and the serialiser. Uses a single clock with strobe handshakes instead of sampling foreign clocks.

Parameters:
SAMPLE_W, 12, bits per sample; must be a multiple of 4
SAMPLES_PER_WORD, 4, samples packed per stored word
ADDR_W, 9, log2 of FIFO depth (DEPTH = 2^ADDR_W words)
ALMOST_EMPTY_TH, 3, almost_empty asserts when count <= this value
EDGE_MODE, 1, 1: wr_tick/rd_tick are levels and act on their rising edge; 0: they are one-cycle strobes

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
begin_acq  in  1  enable; low flushes the FIFO and holds outputs idle
wr_tick  in  1  write request
data_in  in  SAMPLE_W*SAMPLES_PER_WORD  packed word; sample 0 in the MSBs
rd_tick  in  1  read request
data_out  out  (SAMPLE_W/4)*(4*SAMPLES_PER_WORD)  transposed lanes, lane 0 in the MSBs
out_valid  out  1  one-cycle pulse when data_out is updated
count  out  ADDR_W+1  words stored
BRAM_empty  out  1  count == 0
almost_empty  out  1  count <= ALMOST_EMPTY_TH
full  out  1  count == DEPTH
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (sync, highest priority): wr/rd pointers 0, count 0, data_out 0, out_valid 0, overflow 0, underflow 0, edge-detect registers 0. BRAM_empty=1, almost_empty=1, full=0 from the first cycle after reset.
- begin_acq low (no reset): same clearing as reset; edge-detect registers keep tracking their inputs so no false edge appears when begin_acq rises.
- Event detect: EDGE_MODE=1 -> wr_ev = wr_tick & ~wr_tick_d (same for rd); EDGE_MODE=0 -> wr_ev = wr_tick. Events are evaluated only while begin_acq=1.
- Write accepted when wr_ev & (~full | rd_accepted): RAM[wr_ptr] <= data_in; wr_ptr wraps modulo DEPTH.
- Read accepted when rd_ev & ~BRAM_empty: the RAM is read at rd_ptr and rd_ptr increments (wrap). There is no fall-through: a read on an empty FIFO is rejected even if a write is accepted in the same cycle.
- Latency: RAM read data is registered (cycle N+1). The transposed value is loaded into data_out and out_valid pulses in cycle N+2. data_out holds its value until the next accepted read.
- Transpose: nibble j of sample s (j=0 is the MS nibble) maps to lane j, position s (s=0 is the MS nibble of the lane). Default: lane0 = {s0[11:8],s1[11:8],s2[11:8],s3[11:8]}.
- Count: +1 on write only, -1 on read only, unchanged when both or neither. The count is exact and never wraps.
- Simultaneous read and write when full: both are accepted and count stays at DEPTH. Simultaneous read and write when empty: the write is accepted, the read is rejected, underflow is set, and count becomes 1.
- Rejected write (full with no accepted read): sets overflow, leaves memory and pointers unchanged. Rejected read: sets underflow. Both flags clear only on reset or when begin_acq is low.
- Flags are registered from the next count value, so they are valid in the same cycle as count.

Test Plan:
- Reset, then begin_acq=1 with no ticks -> count=0, BRAM_empty=1, almost_empty=1, full=0, data_out=0, no out_valid.
- EDGE_MODE=1: write 48'h123_456_789_ABC, hold wr_tick high for 5 cycles, then rd_tick pulse -> count goes 1 then 0; out_valid is seen 2 cycles after the rd edge; data_out = 48'h147A_258B_369C.
- Write 512 words -> full=1; a 513th write sets overflow=1 and count stays 512. Read 512 words -> they return in order across the pointer wrap, then BRAM_empty=1.
- With count=512, issue a simultaneous read and write -> both accepted, count=512, overflow unchanged; the new word is read back last.
- Empty FIFO with a simultaneous read and write -> count=1, underflow=1, no out_valid; the next read returns the written word.
- Drop begin_acq mid-stream with count=7 -> the next cycle shows count=0, BRAM_empty=1, data_out=0 and flags cleared; raising begin_acq while wr_tick is held high produces no write.

Source files
------------

// File: rtl/acq_transpose_fifo.sv
// Acquisition FIFO: packed ADC words in a simple-dual-port RAM, exact occupancy,
// and a registered read path that emits each word transposed into nibble lanes.
module acq_transpose_fifo #(
    parameter int SAMPLE_W         = 12,
    parameter int SAMPLES_PER_WORD = 4,
    parameter int ADDR_W           = 9,
    parameter int ALMOST_EMPTY_TH  = 3,
    parameter int EDGE_MODE        = 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          begin_acq,
    input  logic                                          wr_tick,
    input  logic [SAMPLE_W*SAMPLES_PER_WORD-1:0]          data_in,
    input  logic                                          rd_tick,
    output logic [(SAMPLE_W/4)*(4*SAMPLES_PER_WORD)-1:0]  data_out,
    output logic                                          out_valid,
    output logic [ADDR_W:0]                               count,
    output logic                                          BRAM_empty,
    output logic                                          almost_empty,
    output logic                                          full,
    output logic                                          overflow,
    output logic                                          underflow
);

    localparam int WORD_W = SAMPLE_W * SAMPLES_PER_WORD;
    localparam int NIB    = SAMPLE_W / 4;
    localparam int LANE_W = 4 * SAMPLES_PER_WORD;
    localparam int OUT_W  = NIB * LANE_W;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   AE_C    = (ADDR_W+1)'(ALMOST_EMPTY_TH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [WORD_W-1:0] r_mem [DEPTH];

    logic              r_wr_d;
    logic              r_rd_d;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_ae;
    logic              r_full;
    logic              r_ovf;
    logic              r_udf;
    logic              r_rd_vld;
    logic [WORD_W-1:0] r_rd_data;
    logic [OUT_W-1:0]  r_data_out;
    logic              r_out_valid;

    logic              w_clr;
    logic              w_wr_ev;
    logic              w_rd_ev;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W:0]   w_count_nxt;
    logic [OUT_W-1:0]  w_xpose;

    assign w_clr = reset | ~begin_acq;

    // Level mode acts on rising edges only; strobe mode takes the tick as-is.
    assign w_wr_ev = begin_acq &
                     ((EDGE_MODE != 0) ? (wr_tick & ~r_wr_d) : wr_tick);
    assign w_rd_ev = begin_acq &
                     ((EDGE_MODE != 0) ? (rd_tick & ~r_rd_d) : rd_tick);

    assign w_rd_acc = w_rd_ev & ~r_empty;
    assign w_wr_acc = w_wr_ev & (~r_full | w_rd_acc);

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Nibble j of sample s lands in lane j, position s.
    always_comb begin
        w_xpose = '0;
        for (int j = 0; j < NIB; j++) begin
            for (int s = 0; s < SAMPLES_PER_WORD; s++) begin
                w_xpose[OUT_W-1-j*LANE_W-4*s -: 4] =
                    r_rd_data[WORD_W-1-s*SAMPLE_W-4*j -: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    // Edge trackers keep following the inputs while idle so enabling is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_d <= 1'b0;
            r_rd_d <= 1'b0;
        end else begin
            r_wr_d <= wr_tick;
            r_rd_d <= rd_tick;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_ae        <= 1'b1;
            r_full      <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_wr_ev && !w_wr_acc) begin
                r_ovf <= 1'b1;
            end
            if (w_rd_ev && !w_rd_acc) begin
                r_udf <= 1'b1;
            end
            r_count     <= w_count_nxt;
            r_empty     <= (w_count_nxt == '0);
            r_ae        <= (w_count_nxt <= AE_C);
            r_full      <= (w_count_nxt == DEPTH_C);
            r_rd_vld    <= w_rd_acc;
            r_out_valid <= r_rd_vld;
            if (r_rd_vld) begin
                r_data_out <= w_xpose;
            end
        end
    end

    assign data_out     = r_data_out;
    assign out_valid    = r_out_valid;
    assign count        = r_count;
    assign BRAM_empty   = r_empty;
    assign almost_empty = r_ae;
    assign full         = r_full;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_acq_transpose_fifo.sv
// Bench for acq_transpose_fifo: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_acq_transpose_fifo;

    localparam int SW    = 12;
    localparam int SPW   = 4;
    localparam int AW    = 9;
    localparam int TH    = 3;
    localparam int DEPTH = 512;
    localparam int WW    = 48;

    logic          clk = 1'b0;
    logic          reset;
    logic          begin_acq;
    logic          wr_tick;
    logic [WW-1:0] data_in;
    logic          rd_tick;
    logic [WW-1:0] data_out;
    logic          out_valid;
    logic [AW:0]   count;
    logic          BRAM_empty;
    logic          almost_empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    acq_transpose_fifo #(
        .SAMPLE_W(SW), .SAMPLES_PER_WORD(SPW), .ADDR_W(AW),
        .ALMOST_EMPTY_TH(TH), .EDGE_MODE(1)
    ) dut (
        .clk(clk), .reset(reset), .begin_acq(begin_acq),
        .wr_tick(wr_tick), .data_in(data_in), .rd_tick(rd_tick),
        .data_out(data_out), .out_valid(out_valid), .count(count),
        .BRAM_empty(BRAM_empty), .almost_empty(almost_empty),
        .full(full), .overflow(overflow), .underflow(underflow)
    );

    int n_pass = 0;
    int n_tot  = 0;

    logic [WW-1:0] mq[$];
    bit            m_ovf, m_udf, m_pw, m_pr, m_av, m_ov;
    logic [WW-1:0] m_ad, m_dout;

    function automatic logic [WW-1:0] xpose(input logic [WW-1:0] w);
        logic [WW-1:0] r;
        int smp, nib;
        r = '0;
        for (int s = 0; s < SPW; s++) begin
            smp = int'((w >> (SW*(SPW-1-s))) & 48'hFFF);
            for (int j = 0; j < SW/4; j++) begin
                nib = (smp >> (4*(SW/4-1-j))) & 15;
                r = r | (48'(nib) << (4*SPW*(SW/4-1-j) + 4*(SPW-1-s)));
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_step(input bit rst, input bit b, input bit w,
                              input bit r, input logic [WW-1:0] d);
        bit wev, rev, rok, wok;
        if (rst || !b) begin
            mq.delete();
            m_ovf = 0; m_udf = 0; m_av = 0; m_ov = 0; m_dout = '0;
            m_pw = rst ? 1'b0 : w;
            m_pr = rst ? 1'b0 : r;
            return;
        end
        wev = w && !m_pw;
        rev = r && !m_pr;
        m_pw = w;
        m_pr = r;
        rok = rev && (mq.size() > 0);
        wok = wev && ((mq.size() < DEPTH) || rok);
        if (rev && !rok) m_udf = 1;
        if (wev && !wok) m_ovf = 1;
        m_ov = m_av;
        if (m_av) m_dout = xpose(m_ad);
        m_av = rok;
        if (rok) m_ad = mq.pop_front();
        if (wok) mq.push_back(d);
    endtask

    task automatic step(input bit rst, input bit b, input bit w,
                        input bit r, input logic [WW-1:0] d);
        int n;
        reset = rst; begin_acq = b; wr_tick = w; rd_tick = r; data_in = d;
        @(posedge clk);
        #1;
        model_step(rst, b, w, r, d);
        n = mq.size();
        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(BRAM_empty), 64'(n == 0));
        chk("almost_empty", 64'(almost_empty), 64'(n <= TH));
        chk("full", 64'(full), 64'(n == DEPTH));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("underflow", 64'(underflow), 64'(m_udf));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("data_out", 64'(data_out), 64'(m_dout));
    endtask

    task automatic wr_word(input logic [WW-1:0] d);
        step(0, 1, 1, 0, d);
        step(0, 1, 0, 0, d);
    endtask

    task automatic rd_one();
        step(0, 1, 0, 1, '0);
        step(0, 1, 0, 0, '0);
    endtask

    typedef struct {
        bit            b, w, r;
        logic [WW-1:0] d;
        int            cnt;
        bit            ov;
        logic [WW-1:0] dout;
    } vec_t;

    vec_t          tbl[11];
    logic [WW-1:0] nw, ew, rw;

    initial begin
        for (int i = 0; i < 11; i++) begin
            tbl[i].b = 1; tbl[i].w = 0; tbl[i].r = 0;
            tbl[i].d = 48'h123456789ABC;
            tbl[i].cnt = 0; tbl[i].ov = 0; tbl[i].dout = '0;
        end
        for (int i = 1; i <= 5; i++) tbl[i].w = 1;
        for (int i = 1; i <= 6; i++) tbl[i].cnt = 1;
        tbl[7].r = 1;
        tbl[8].ov = 1;
        for (int i = 8; i <= 10; i++) tbl[i].dout = 48'h147A258B369C;

        reset = 1; begin_acq = 0; wr_tick = 0; rd_tick = 0; data_in = '0;
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        chk("reset empty", 64'(BRAM_empty), 64'd1);
        chk("reset ae", 64'(almost_empty), 64'd1);

        for (int i = 0; i < 11; i++) begin
            step(0, tbl[i].b, tbl[i].w, tbl[i].r, tbl[i].d);
            chk($sformatf("tbl%0d count", i), 64'(count), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d valid", i), 64'(out_valid), 64'(tbl[i].ov));
            chk($sformatf("tbl%0d dout", i), 64'(data_out), 64'(tbl[i].dout));
        end

        step(0, 0, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            wr_word({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
        end
        chk("fill full", 64'(full), 64'd1);
        chk("fill ovf", 64'(overflow), 64'd0);
        wr_word(48'hDEAD_BEEF_0001);
        chk("ovf set", 64'(overflow), 64'd1);
        chk("ovf count", 64'(count), 64'd512);
        nw = 48'hA5A_5A5_C3C_3C3;
        step(0, 1, 1, 1, nw);
        step(0, 1, 0, 0, '0);
        chk("rw full count", 64'(count), 64'd512);
        chk("rw full ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < DEPTH; i++) rd_one();
        chk("drain empty", 64'(BRAM_empty), 64'd1);
        chk("last word", 64'(data_out), 64'(xpose(nw)));

        ew = 48'h0F1_E2D_3C4_B5A;
        step(0, 1, 1, 1, ew);
        chk("erw count", 64'(count), 64'd1);
        chk("erw udf", 64'(underflow), 64'd1);
        step(0, 1, 0, 0, '0);
        chk("erw nov1", 64'(out_valid), 64'd0);
        step(0, 1, 0, 0, '0);
        chk("erw nov2", 64'(out_valid), 64'd0);
        rd_one();
        chk("erw data", 64'(data_out), 64'(xpose(ew)));
        chk("erw valid", 64'(out_valid), 64'd1);

        for (int i = 0; i < 8; i++) wr_word(48'(64'h1111_1111_1111 * (i + 1)));
        rd_one();
        chk("drop pre count", 64'(count), 64'd7);
        step(0, 0, 0, 0, '0);
        chk("drop count", 64'(count), 64'd0);
        chk("drop empty", 64'(BRAM_empty), 64'd1);
        chk("drop dout", 64'(data_out), 64'd0);
        chk("drop udf", 64'(underflow), 64'd0);
        chk("drop ovf", 64'(overflow), 64'd0);
        rw = 48'h777_888_999_AAA;
        step(0, 0, 1, 0, rw);
        step(0, 1, 1, 0, rw);
        chk("rise held", 64'(count), 64'd0);
        step(0, 1, 1, 0, rw);
        chk("rise held2", 64'(count), 64'd0);
        step(0, 1, 0, 0, '0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 149) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0,
                 {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
